// File: rtl/tone_envelope_synth.sv
// Square-wave tone generator with attack/sustain/release envelope and a
// two-cycle valid/ready sample port for the audio controller.
module tone_envelope_synth #(
  parameter int PERIOD_W = 19,
  parameter int ENV_DIV  = 50000,
  parameter int ATK_STEP = 8,
  parameter int REL_STEP = 4,
  parameter int AMP_UNIT = 3921568
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [PERIOD_W-1:0] note_half_period,
  input  logic                note_load,
  input  logic                mute,
  input  logic                sample_ready,
  output logic                sample_valid,
  output logic signed [31:0]  sample,
  output logic [1:0]          env_state
);

  localparam int DIV_W = (ENV_DIV > 2) ? $clog2(ENV_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ATTACK  = 2'd1,
    S_SUSTAIN = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  logic [PERIOD_W-1:0] r_per;
  logic [PERIOD_W-1:0] r_ph_cnt;
  logic                r_phase;
  logic [DIV_W-1:0]    r_div;
  logic [7:0]          r_level;
  state_t              r_state;
  logic signed [31:0]  r_sample_p1;
  logic                r_vld_p1;

  logic w_load_nz;
  logic w_tick;
  logic [7:0] w_atk_level;
  logic [7:0] w_rel_level;

  function automatic logic [7:0] sat_add(input logic [7:0] lvl);
    logic [8:0] s;
    s = {1'b0, lvl} + 9'(ATK_STEP);
    return (s > 9'd255) ? 8'd255 : s[7:0];
  endfunction

  function automatic logic [7:0] sat_sub(input logic [7:0] lvl);
    return ({1'b0, lvl} <= 9'(REL_STEP)) ? 8'd0 : 8'(lvl - 8'(REL_STEP));
  endfunction

  // Magnitude fits in 31 bits, so the sign bit is always free for negation.
  function automatic logic signed [31:0] shape_sample(input logic [7:0] lvl,
                                                      input logic ph,
                                                      input logic mt);
    logic [30:0]        mag;
    logic signed [31:0] pos;
    mag = 31'(lvl) * 31'(AMP_UNIT);
    pos = signed'({1'b0, mag});
    if (mt)      return 32'sd0;
    else if (ph) return pos;
    else         return -pos;
  endfunction

  assign w_load_nz   = note_load && (note_half_period != '0);
  assign w_tick      = (r_div == DIV_W'(ENV_DIV - 1));
  assign w_atk_level = sat_add(r_level);
  assign w_rel_level = sat_sub(r_level);

  // Oscillator: half-period counter and square-wave phase
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_per    <= '0;
      r_ph_cnt <= '0;
      r_phase  <= 1'b1;
    end else if (w_load_nz) begin
      r_per    <= note_half_period;
      r_ph_cnt <= '0;
      r_phase  <= 1'b1;
    end else if (r_per == '0) begin
      r_ph_cnt <= '0;
      r_phase  <= 1'b1;
    end else if (r_ph_cnt == r_per) begin
      r_ph_cnt <= '0;
      r_phase  <= ~r_phase;
    end else begin
      r_ph_cnt <= r_ph_cnt + PERIOD_W'(1);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset || w_tick) r_div <= '0;
    else                 r_div <= r_div + DIV_W'(1);
  end

  // Envelope FSM: a load in the same cycle as a tick swallows the tick
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_level <= 8'd0;
    end else if (note_load) begin
      case (r_state)
        S_IDLE:    if (w_load_nz)  r_state <= S_ATTACK;
        S_ATTACK:  if (!w_load_nz) r_state <= S_RELEASE;
        S_SUSTAIN: if (!w_load_nz) r_state <= S_RELEASE;
        S_RELEASE: if (w_load_nz)  r_state <= S_ATTACK;
        default:   r_state <= S_IDLE;
      endcase
    end else if (w_tick) begin
      case (r_state)
        S_ATTACK: begin
          r_level <= w_atk_level;
          if (w_atk_level == 8'd255) r_state <= S_SUSTAIN;
        end
        S_SUSTAIN: r_level <= 8'd255;
        S_RELEASE: begin
          r_level <= w_rel_level;
          if (w_rel_level == 8'd0) r_state <= S_IDLE;
        end
        default: r_level <= r_level;
      endcase
    end
  end

  // Output stage p1: capture while empty, drop valid for one cycle after a transfer
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_vld_p1    <= 1'b0;
      r_sample_p1 <= 32'sd0;
    end else if (r_vld_p1 && sample_ready) begin
      r_vld_p1    <= 1'b0;
    end else if (!r_vld_p1) begin
      r_sample_p1 <= shape_sample(r_level, r_phase, mute);
      r_vld_p1    <= 1'b1;
    end
  end

  assign sample_valid = r_vld_p1;
  assign sample       = r_sample_p1;
  assign env_state    = r_state;

endmodule

// File: tb/tb_tone_envelope_synth.sv
// Randomised scoreboard bench for tone_envelope_synth with a spec-level
// reference model (phase from elapsed cycles, envelope from the rule table).
module tb_tone_envelope_synth;

  localparam int PW       = 19;
  localparam int ENV_DIV  = 4;
  localparam int ATK_STEP = 64;
  localparam int REL_STEP = 85;
  localparam int AMP_UNIT = 3921568;

  logic                CLOCK_50 = 1'b0;
  logic                reset = 1'b1;
  logic [PW-1:0]       note_half_period = '0;
  logic                note_load = 1'b0;
  logic                mute = 1'b0;
  logic                sample_ready = 1'b0;
  logic                sample_valid;
  logic signed [31:0]  sample;
  logic [1:0]          env_state;

  tone_envelope_synth #(
    .PERIOD_W(PW), .ENV_DIV(ENV_DIV), .ATK_STEP(ATK_STEP),
    .REL_STEP(REL_STEP), .AMP_UNIT(AMP_UNIT)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .note_half_period(note_half_period),
    .note_load(note_load), .mute(mute), .sample_ready(sample_ready),
    .sample_valid(sample_valid), .sample(sample), .env_state(env_state)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  // Reference model state
  int m_state, m_level, m_per, m_k, m_div;
  bit m_valid;
  logic signed [31:0] exp_q[$];

  function automatic bit ref_phase(int per, int k);
    if (per == 0) return 1'b1;
    return ((k / (per + 1)) % 2) == 0;
  endfunction

  task automatic model_edge(input logic r, input logic ld, input int v,
                            input logic rd, input logic mt);
    bit  tick, ph;
    longint mag;
    if (r) begin
      m_state = 0; m_level = 0; m_per = 0; m_k = 0; m_div = 0; m_valid = 0;
      exp_q.delete();
      return;
    end
    tick = (m_div == ENV_DIV - 1);
    ph   = ref_phase(m_per, m_k);
    if (m_valid && rd) m_valid = 0;
    else if (!m_valid) begin
      mag = longint'(m_level) * AMP_UNIT;
      if (mt)      exp_q.push_back(32'sd0);
      else if (ph) exp_q.push_back(32'(mag));
      else         exp_q.push_back(32'(-mag));
      m_valid = 1;
    end
    if (ld) begin
      if (v != 0) begin
        if (m_state == 0 || m_state == 3) m_state = 1;
      end else if (m_state == 1 || m_state == 2) m_state = 3;
    end else if (tick) begin
      if (m_state == 1) begin
        m_level = (m_level + ATK_STEP > 255) ? 255 : m_level + ATK_STEP;
        if (m_level == 255) m_state = 2;
      end else if (m_state == 3) begin
        m_level = (m_level - REL_STEP < 0) ? 0 : m_level - REL_STEP;
        if (m_level == 0) m_state = 0;
      end
    end
    if (ld && v != 0) begin
      m_per = v; m_k = 0;
    end else m_k++;
    m_div = (m_div + 1) % ENV_DIV;
  endtask

  task automatic step(input logic r, input logic ld, input int v,
                      input logic rd, input logic mt);
    reset = r; note_load = ld; note_half_period = PW'(v);
    sample_ready = rd; mute = mt;
    @(posedge CLOCK_50);
    model_edge(r, ld, v, rd, mt);
    started = 1;
    #1;
  endtask

  task automatic idle(input int n, input logic rd, input logic mt);
    for (int i = 0; i < n; i++) step(0, 0, 0, rd, mt);
  endtask

  // Monitor: per-cycle state/valid checks, hold stability, scoreboard pops
  bit prev_hold = 0;
  logic signed [31:0] prev_sample;
  always @(negedge CLOCK_50) begin
    if (started) begin
      checks++;
      if (env_state !== 2'(m_state)) begin
        errors++;
        $display("FAIL env_state: got %0d expected %0d at %0t", env_state, m_state, $time);
      end
      checks++;
      if (sample_valid !== m_valid) begin
        errors++;
        $display("FAIL sample_valid: got %0b expected %0b at %0t", sample_valid, m_valid, $time);
      end
      if (prev_hold) begin
        checks++;
        if (!sample_valid || sample !== prev_sample) begin
          errors++;
          $display("FAIL hold: got valid=%0b sample=%0d expected valid=1 sample=%0d", sample_valid, sample, prev_sample);
        end
      end
      if (sample_valid && sample_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sample_pop: got %0d expected none queued at %0t", sample, $time);
        end else begin
          logic signed [31:0] e;
          e = exp_q.pop_front();
          if (sample !== e) begin
            errors++;
            $display("FAIL sample: got %0d expected %0d at %0t", sample, e, $time);
          end
        end
      end
      prev_hold   = sample_valid && !sample_ready && !reset;
      prev_sample = sample;
    end
  end

  task automatic wait_for(input int st, input int lvl_or_div, input bit by_div, input string nm);
    int n = 0;
    while (!(m_state == st && (by_div ? (m_div == lvl_or_div) : (m_level == lvl_or_div))) && n < 60) begin
      step(0, 0, 0, 1, 0);
      n++;
    end
    if (n >= 60) begin
      checks++; errors++;
      $display("FAIL %s: got state=%0d level=%0d expected condition within 60 cycles", nm, m_state, m_level);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0);
    idle(3, 1, 0);
    // Attack to sustain with pitch 3
    step(0, 1, 3, 1, 0);
    idle(24, 1, 0);
    // Release, then retrigger at level 85
    step(0, 1, 0, 1, 0);
    wait_for(3, 85, 0, "reach_85");
    step(0, 1, 5, 1, 0);
    idle(24, 1, 0);
    // Backpressure during release ticks
    step(0, 1, 0, 1, 0);
    idle(10, 0, 0);
    idle(1, 1, 0);
    idle(20, 1, 0);
    // Load/tick collision in attack
    step(0, 1, 2, 1, 0);
    wait_for(1, ENV_DIV - 1, 1, "attack_tick");
    step(0, 1, 0, 1, 0);
    idle(20, 1, 0);
    // Mute in sustain
    step(0, 1, 4, 1, 0);
    idle(20, 1, 0);
    idle(6, 1, 1);
    idle(4, 1, 0);
    // Reset with a pending sample held
    idle(3, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0);
    idle(4, 1, 0);
    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      logic r, ld, rd, mt;
      int v;
      r  = ($urandom_range(0, 599) == 0);
      ld = ($urandom_range(0, 14) == 0);
      v  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 9));
      rd = ($urandom_range(0, 3) != 0);
      mt = ($urandom_range(0, 11) == 0);
      step(r, ld, v, rd, mt);
    end
    idle(4, 1, 0);
    @(negedge CLOCK_50);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tone_envelope_synth.md
# tone_envelope_synth

Tone synthesis stage that sits between the note-ROM sequencer and `Audio_Controller`. It takes half-period note values and load strobes from the sequencer. It generates a square wave whose amplitude follows an attack/sustain/release envelope, so note changes and rests do not click. It presents signed 32-bit samples through a valid/ready handshake that plugs directly into the controller's `audio_out_allowed` / `write_audio_out` pair.

## Interface
Parameters:
- `PERIOD_W`, default 19: width of the half-period value.
- `ENV_DIV`, default 50000: clocks per envelope tick (1 kHz at 50 MHz); must be ≥ 2.
- `ATK_STEP`, default 8: level increment per tick in ATTACK (1..255).
- `REL_STEP`, default 4: level decrement per tick in RELEASE (1..255).
- `AMP_UNIT`, default 3921568: sample magnitude per envelope level unit; must satisfy 255·AMP_UNIT < 2^31.

Ports:
- `CLOCK_50`, in, 1: sole clock; all logic on its rising edge.
- `reset`, in, 1: synchronous, active-high.
- `note_half_period`, in, PERIOD_W: half-period in clocks minus 1; 0 means rest.
- `note_load`, in, 1: one-cycle strobe that latches `note_half_period`.
- `mute`, in, 1: forces captured samples to 0 without changing envelope state.
- `sample_ready`, in, 1: consumer can accept; tied to `audio_out_allowed`.
- `sample_valid`, out, 1: `sample` holds a valid value; drives `write_audio_out`.
- `sample`, out, 32: two's-complement sample, same value to both channels.
- `env_state`, out, 2: IDLE=0, ATTACK=1, SUSTAIN=2, RELEASE=3.

## Operation
- **Period register `per`.** It loads from `note_half_period` only on `note_load` with a nonzero value. Loading 0 leaves `per` unchanged, so the old pitch continues to sound during release.
- **Oscillator.**
  - On a nonzero load, `ph_cnt` is set to 0 and `phase` is set to 1.
  - Otherwise, if `ph_cnt == per`, `ph_cnt` is set to 0 and `phase` toggles; if not, `ph_cnt` increments.
  - While `per == 0` (only possible after reset), `ph_cnt` stays 0 and `phase` stays 1.
- **Envelope prescaler.** Free-running counter 0..ENV_DIV-1. `tick` is asserted in the cycle the count equals ENV_DIV-1.
- **Envelope level.** 8-bit unsigned `level`.
- **FSM transitions.** `note_load` has priority; a tick in the same cycle is ignored.
  - IDLE: on a nonzero load, go to ATTACK.
  - ATTACK: on tick, `level = min(level+ATK_STEP, 255)`. Go to SUSTAIN in the same cycle `level` reaches 255.
  - SUSTAIN: `level` is held at 255.
  - RELEASE: on tick, `level = max(level-REL_STEP, 0)`. Go to IDLE in the same cycle `level` reaches 0.
  - A nonzero load in ATTACK or SUSTAIN keeps the state (legato); only the period changes.
  - A nonzero load in RELEASE goes to ATTACK and keeps the current `level` (no restart from 0).
  - A load of 0 in ATTACK or SUSTAIN goes to RELEASE.
  - A load of 0 in IDLE or RELEASE has no effect.
- **Sample arithmetic.**
  - `mag` = `level` × AMP_UNIT, computed as unsigned 31 bits.
  - `sample` = `+mag` when `phase` = 1, `−mag` when `phase` = 0, and 0 when `mute` = 1.
  - No overflow is possible, given the AMP_UNIT constraint.
- **Output handshake.**
  - A transfer occurs in a cycle with `sample_valid` && `sample_ready`.
  - In the cycle after a transfer, `sample_valid` = 0, and `sample` captures a fresh value from the current `phase`, `level` and `mute`.
  - In the following cycle, `sample_valid` = 1.
  - While `sample_valid` = 1 and `sample_ready` = 0, `sample` and `sample_valid` hold stable.
  - Maximum throughput is one sample per 2 clocks.

## Timing
- **Reset values:** `sample` = 0, `sample_valid` = 0, `env_state` = IDLE, `level` = 0, `per` = 0, `ph_cnt` = 0, `phase` = 1, prescaler = 0.
- **First sample after reset:** in the first cycle after `reset` falls, `sample` is captured. In the second cycle, `sample_valid` = 1.
- **Note load:** `per`, `ph_cnt`, `phase` and `env_state` update on the edge that samples `note_load`.
- **Envelope:** `level` and `env_state` update on the edge that samples `tick`.
- **Capture latency:** a captured sample reflects register state as of the capture edge. It is visible at the `sample` port for the entire following valid interval.
- **Reset mid-operation:** all outputs return to their reset values on the next edge. A pending, untransferred sample is discarded.

## Test plan
1. **Reset.**
   - Stimulus: assert `reset` for 3 cycles, then release.
   - Required: `sample_valid` = 0 and `env_state` = 0 while in reset; `sample_valid` = 1 with `sample` = 0 two cycles after release.
2. **Attack and pitch.**
   - Stimulus: ENV_DIV=4, ATK_STEP=64; load 3 with `sample_ready` tied high.
   - Required: `phase` toggles every 4 clocks; `level` steps 64, 128, 192, 255 on successive ticks; `env_state` becomes 2 on the 4th tick; peak `sample` = ±999999840.
3. **Release.**
   - Stimulus: REL_STEP=85; from SUSTAIN, load 0.
   - Required: `env_state` = 3; `level` steps 170, 85, 0, reaching IDLE on the 3rd tick; `sample` alternates sign at the old period until IDLE, then is 0.
4. **Retrigger.**
   - Stimulus: during RELEASE at `level` 85, load 5.
   - Required: `env_state` becomes 1; next tick gives `level` 149; `phase` restarts at 1 and toggles every 6 clocks.
5. **Backpressure.**
   - Stimulus: hold `sample_ready` = 0 for 10 cycles while the envelope ticks, then pulse it for 1 cycle.
   - Required: `sample` and `sample_valid` remain constant for all 10 cycles; `sample_valid` = 0 for one cycle after the pulse; the next valid sample reflects the updated level.
6. **Collision and mute.**
   - Stimulus: assert `note_load`(0) in the same cycle as a tick in ATTACK.
   - Required: RELEASE is entered and that tick's increment is dropped.
   - Stimulus: assert `mute` in SUSTAIN.
   - Required: the next captured `sample` = 0 and `env_state` stays 2.
